// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton tick generator.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_e;

  localparam int DEBOUNCE_DEF = 4;
  localparam int REPEAT_DEF   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs, clears to 0.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic meta;

  // two back-to-back flops; only q may be consumed by downstream logic
  always_ff @(posedge clk) begin
    if (clr) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_tick_gen.sv
// Pushbutton conditioner: synchroniser + debounce FSM producing a one-cycle
// count-enable tick per accepted press and a debounced level.
// Optional build macro AUTO_REPEAT_EN: emits an extra tick every REPEAT
// cycles while the button stays held.
module btn_tick_gen
  import btn_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int REPEAT   = REPEAT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_in,
  output logic tick,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT - 1);
`endif

  // reject parameter values the shared counter cannot represent
  if (DEBOUNCE < 1 || DEBOUNCE > (2**CNT_W) - 1) begin : g_db_chk
    $error("btn_tick_gen: DEBOUNCE out of range");
  end
  if (REPEAT < 1 || REPEAT > (2**CNT_W) - 1) begin : g_rp_chk
    $error("btn_tick_gen: REPEAT out of range");
  end

  logic             btn_s;
  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick_nxt, pressed_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .clr (clr),
    .d   (btn_in),
    .q   (btn_s)
  );

  // state, counter and registered outputs; clr wins over any pending tick
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      tick    <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tick    <= tick_nxt;
      pressed <= pressed_nxt;
    end
  end

  // debounce transitions; tick defaults low so it never lasts beyond a cycle
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tick_nxt    = 1'b0;
    pressed_nxt = pressed;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = HELD;
          tick_nxt    = 1'b1;
          pressed_nxt = 1'b1;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end else begin
`ifdef AUTO_REPEAT_EN
          if (cnt == RP_LAST) begin
            tick_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      REL_WAIT: begin
        if (btn_s) begin
          // release glitch absorbed; repeat period restarts without a tick
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = IDLE;
          pressed_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_tick_gen.sv
// Directed bench for btn_tick_gen with DEBOUNCE=4, REPEAT=8.
// tick_cnt stands in for the downstream 4-bit counter value.
module tb_btn_tick_gen;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_in = 1'b0;
  logic tick, pressed;

  int n_chk  = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int base;

  btn_tick_gen #(.CNT_W(8), .DEBOUNCE(4), .REPEAT(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .btn_in  (btn_in),
    .tick    (tick),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  // downstream counter model: one increment per observed tick cycle
  always @(negedge clk) if (tick === 1'b1) tick_cnt = tick_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset held with button toggling
    for (int i = 0; i < 3; i++) begin
      btn_in = i[0];
      step();
      chk("rst_tick", int'(tick), 0);
      chk("rst_pressed", int'(pressed), 0);
    end
    chk("rst_q", tick_cnt, 0);
    clr = 1'b0;
    btn_in = 1'b0;
    steps(4);
    chk("idle_pressed", int'(pressed), 0);

`ifdef AUTO_REPEAT_EN
    // 6: auto-repeat while held
    base = tick_cnt;
    btn_in = 1'b1;
    steps(7);
    chk("ar_first_tick", int'(tick), 1);
    for (int j = 1; j <= 30; j++) begin
      step();
      chk($sformatf("ar_tick_%0d", j), int'(tick), (j % 8 == 0) ? 1 : 0);
    end
    chk("ar_q", tick_cnt - base, 4);
    btn_in = 1'b0;
    steps(8);
    chk("ar_release", int'(pressed), 0);
`else
    // 2: clean press, 20 cycles high
    base = tick_cnt;
    btn_in = 1'b1;
    steps(6);
    chk("cp_tick_early", int'(tick), 0);
    chk("cp_pressed_early", int'(pressed), 0);
    step();
    chk("cp_tick", int'(tick), 1);
    chk("cp_pressed", int'(pressed), 1);
    step();
    chk("cp_tick_clear", int'(tick), 0);
    steps(12);
    chk("cp_held", int'(pressed), 1);
    btn_in = 1'b0;
    steps(6);
    chk("cp_rel_early", int'(pressed), 1);
    step();
    chk("cp_rel", int'(pressed), 0);
    chk("cp_q", tick_cnt - base, 1);

    // 3: bounce 1,1,0 x3 then low
    base = tick_cnt;
    for (int i = 0; i < 9; i++) begin
      btn_in = (i % 3 != 2);
      step();
      chk($sformatf("bn_pressed_%0d", i), int'(pressed), 0);
    end
    btn_in = 1'b0;
    steps(6);
    chk("bn_pressed_end", int'(pressed), 0);
    chk("bn_q", tick_cnt - base, 0);

    // 4: release glitch while held
    base = tick_cnt;
    btn_in = 1'b1;
    steps(10);
    chk("gl_pressed", int'(pressed), 1);
    btn_in = 1'b0;
    steps(2);
    btn_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("gl_hold_%0d", i), int'(pressed), 1);
    end
    btn_in = 1'b0;
    steps(7);
    chk("gl_rel", int'(pressed), 0);
    chk("gl_q", tick_cnt - base, 1);

    // 5: clr pulse while held, button kept high
    btn_in = 1'b1;
    steps(10);
    chk("rh_pressed", int'(pressed), 1);
    base = tick_cnt;
    clr = 1'b1;
    step();
    chk("rh_clr_tick", int'(tick), 0);
    chk("rh_clr_pressed", int'(pressed), 0);
    clr = 1'b0;
    steps(6);
    chk("rh_tick_early", int'(tick), 0);
    chk("rh_pressed_early", int'(pressed), 0);
    step();
    chk("rh_tick", int'(tick), 1);
    chk("rh_pressed_new", int'(pressed), 1);
    steps(5);
    chk("rh_q", tick_cnt - base, 1);

    // clr coinciding with the debounce terminal count
    btn_in = 1'b0;
    steps(8);
    base = tick_cnt;
    btn_in = 1'b1;
    steps(6);
    clr = 1'b1;
    step();
    chk("tc_clr_tick", int'(tick), 0);
    chk("tc_clr_pressed", int'(pressed), 0);
    clr = 1'b0;
    btn_in = 1'b0;
    steps(8);
    chk("tc_q", tick_cnt - base, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
